pwm_ctrl: RTL and testbench

Sequencing and configuration controller for `pwm_gen`. It owns the period counter, which drives `count_val`. It double-buffers PWM configuration (period, compares, function) so that updates take effect only at a period boundary, and it runs a start/stop state machine that gates `pwm_en` so a stop always completes the current period cleanly. It sits between the register/config interface and `pwm_gen`; its outputs connect one-to-one to `pwm_gen` inputs.

---
 rtl/pwm_pkg.sv | 18 +
 rtl/pwm_ctrl_counter.sv | 53 +++++
 rtl/pwm_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pwm_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM controller: FSM states, function codes, default widths.
package pwm_pkg;

    localparam int unsigned CNT_W_DEF   = 16;
    localparam int unsigned PRESC_W_DEF = 8;
    localparam int unsigned FUNC_W      = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } pwm_state_e;

    localparam logic [1:0] FUNC_ALIGN_LEFT  = 2'b00;
    localparam logic [1:0] FUNC_ALIGN_RIGHT = 2'b01;
    localparam logic [1:0] FUNC_RANGE       = 2'b10;

endpackage

// File: rtl/pwm_ctrl_counter.sv
// Prescaler plus period counter; flags the wrap both combinationally (for same-edge
// decisions in the controller) and as a registered one-cycle tick.
module pwm_ctrl_counter #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_run,
    input  logic               i_clear,
    input  logic [CNT_W-1:0]   i_period,
    input  logic [PRESC_W-1:0] i_prescale,
    output logic [CNT_W-1:0]   o_count,
    output logic               o_tick,
    output logic               o_wrap_c
);

    logic [PRESC_W-1:0] r_presc;
    logic [CNT_W-1:0]   r_count;
    logic               r_tick;

    logic               w_adv;
    logic [CNT_W:0]     w_sum;
    logic               w_at_end;

    // Compare in CNT_W+1 bits so a full-scale period still wraps; period 0/1 always wraps.
    assign w_adv    = i_run && (r_presc == i_prescale);
    assign w_sum    = {1'b0, r_count} + (CNT_W+1)'(1);
    assign w_at_end = (i_period <= CNT_W'(1)) || (w_sum == {1'b0, i_period});
    assign o_wrap_c = w_adv && w_at_end;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_presc <= '0;
            r_count <= '0;
            r_tick  <= 1'b0;
        end else if (i_run) begin
            if (w_adv) begin
                r_presc <= '0;
                r_count <= w_at_end ? '0 : w_sum[CNT_W-1:0];
            end else begin
                r_presc <= r_presc + PRESC_W'(1);
            end
            r_tick <= o_wrap_c;
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign o_count = r_count;
    assign o_tick  = r_tick;

endmodule

// File: rtl/pwm_ctrl.sv
// PWM sequencing controller: start/stop FSM, double-buffered configuration, and the
// period counter feeding pwm_gen.
module pwm_ctrl
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned PRESC_W = PRESC_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CNT_W-1:0]   cfg_period,
    input  logic [CNT_W-1:0]   cfg_compare1,
    input  logic [CNT_W-1:0]   cfg_compare2,
    input  logic [FUNC_W-1:0]  cfg_functions,
    input  logic [PRESC_W-1:0] cfg_prescale,
    input  logic               start,
    input  logic               stop,
    output logic               pwm_en,
    output logic [CNT_W-1:0]   period,
    output logic [CNT_W-1:0]   compare1,
    output logic [CNT_W-1:0]   compare2,
    output logic [FUNC_W-1:0]  functions,
    output logic [CNT_W-1:0]   count_val,
    output logic               period_tick,
    output logic               busy
);

    pwm_state_e r_state;
    pwm_state_e w_state_nxt;
    logic       r_pwm_en;
    logic       r_busy;

    logic       r_cfg_ready;
    logic       r_loaded;

    logic [CNT_W-1:0]   r_pend_period;
    logic [CNT_W-1:0]   r_pend_compare1;
    logic [CNT_W-1:0]   r_pend_compare2;
    logic [FUNC_W-1:0]  r_pend_functions;
    logic [PRESC_W-1:0] r_pend_prescale;

    logic [CNT_W-1:0]   r_period;
    logic [CNT_W-1:0]   r_compare1;
    logic [CNT_W-1:0]   r_compare2;
    logic [FUNC_W-1:0]  r_functions;
    logic [PRESC_W-1:0] r_prescale;

    logic       w_run;
    logic       w_clear;
    logic       w_wrap;
    logic       w_hs;

    assign w_run   = (r_state != IDLE);
    assign w_clear = (r_state == IDLE);
    assign w_hs    = cfg_valid && r_cfg_ready;

    pwm_ctrl_counter #(
        .CNT_W   (CNT_W),
        .PRESC_W (PRESC_W)
    ) u_counter (
        .clk        (clk),
        .rst        (rst),
        .i_run      (w_run),
        .i_clear    (w_clear),
        .i_period   (r_period),
        .i_prescale (r_prescale),
        .o_count    (count_val),
        .o_tick     (period_tick),
        .o_wrap_c   (w_wrap)
    );

    // Next-state logic; stop dominates start, and a stop only retires on the wrap edge.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start && !stop && r_loaded) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    w_state_nxt = STOPPING;
                end
            end
            STOPPING: begin
                if (w_wrap) begin
                    w_state_nxt = IDLE;
                end else if (start && !stop) begin
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_pwm_en <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pwm_en <= (w_state_nxt != IDLE);
            r_busy   <= (w_state_nxt != IDLE);
        end
    end

    // Idle loads go straight to active; running loads wait in the slot for the next wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg_ready      <= 1'b1;
            r_loaded         <= 1'b0;
            r_pend_period    <= '0;
            r_pend_compare1  <= '0;
            r_pend_compare2  <= '0;
            r_pend_functions <= '0;
            r_pend_prescale  <= '0;
            r_period         <= '0;
            r_compare1       <= '0;
            r_compare2       <= '0;
            r_functions      <= '0;
            r_prescale       <= '0;
        end else if (r_state == IDLE) begin
            if (!r_cfg_ready) begin
                r_period    <= r_pend_period;
                r_compare1  <= r_pend_compare1;
                r_compare2  <= r_pend_compare2;
                r_functions <= r_pend_functions;
                r_prescale  <= r_pend_prescale;
                r_cfg_ready <= 1'b1;
                r_loaded    <= 1'b1;
            end else if (cfg_valid) begin
                r_period    <= cfg_period;
                r_compare1  <= cfg_compare1;
                r_compare2  <= cfg_compare2;
                r_functions <= cfg_functions;
                r_prescale  <= cfg_prescale;
                r_loaded    <= 1'b1;
            end
        end else begin
            if (w_wrap && !r_cfg_ready) begin
                r_period    <= r_pend_period;
                r_compare1  <= r_pend_compare1;
                r_compare2  <= r_pend_compare2;
                r_functions <= r_pend_functions;
                r_prescale  <= r_pend_prescale;
                r_cfg_ready <= 1'b1;
            end
            if (w_hs) begin
                r_pend_period    <= cfg_period;
                r_pend_compare1  <= cfg_compare1;
                r_pend_compare2  <= cfg_compare2;
                r_pend_functions <= cfg_functions;
                r_pend_prescale  <= cfg_prescale;
                r_cfg_ready      <= 1'b0;
            end
        end
    end

    assign cfg_ready = r_cfg_ready;
    assign pwm_en    = r_pwm_en;
    assign busy      = r_busy;
    assign period    = r_period;
    assign compare1  = r_compare1;
    assign compare2  = r_compare2;
    assign functions = r_functions;

endmodule

// File: tb/tb_pwm_ctrl.sv
// Directed bench for pwm_ctrl: start, boundary updates, graceful stop, prescale, reset.
module tb_pwm_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [15:0] cfg_period = '0;
    logic [15:0] cfg_compare1 = '0;
    logic [15:0] cfg_compare2 = '0;
    logic [7:0]  cfg_functions = '0;
    logic [7:0]  cfg_prescale = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        pwm_en;
    logic [15:0] period;
    logic [15:0] compare1;
    logic [15:0] compare2;
    logic [7:0]  functions;
    logic [15:0] count_val;
    logic        period_tick;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pwm_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_period    (cfg_period),
        .cfg_compare1  (cfg_compare1),
        .cfg_compare2  (cfg_compare2),
        .cfg_functions (cfg_functions),
        .cfg_prescale  (cfg_prescale),
        .start         (start),
        .stop          (stop),
        .pwm_en        (pwm_en),
        .period        (period),
        .compare1      (compare1),
        .compare2      (compare2),
        .functions     (functions),
        .count_val     (count_val),
        .period_tick   (period_tick),
        .busy          (busy)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reset, load one config while idle, then start; returns just after the start edge.
    task automatic fresh_start(input logic [15:0] per, input logic [15:0] c1,
                               input logic [15:0] c2, input logic [7:0] fn,
                               input logic [7:0] ps);
        rst = 1'b1;
        step();
        rst = 1'b0;
        cfg_valid = 1'b1;
        cfg_period = per;
        cfg_compare1 = c1;
        cfg_compare2 = c2;
        cfg_functions = fn;
        cfg_prescale = ps;
        step();
        cfg_valid = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (pwm_en !== 1'b0 || busy !== 1'b0 || count_val !== 16'd0 || period_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: pwm_en=%b busy=%b count=%0d tick=%b required 0/0/0/0",
                     pwm_en, busy, count_val, period_tick);
        end
        checks++;
        if (cfg_ready !== 1'b1 || period !== 16'd0 || compare1 !== 16'd0 || functions !== 8'd0) begin
            errors++;
            $display("FAIL reset_cfg: ready=%b period=%0d c1=%0d func=%0d required 1/0/0/0",
                     cfg_ready, period, compare1, functions);
        end
        rst = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (pwm_en !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL start_no_cfg: pwm_en=%b busy=%b required 0/0", pwm_en, busy);
        end
    endtask

    task automatic test_start();
        fresh_start(16'd10, 16'd3, 16'd7, 8'h00, 8'd0);
        checks++;
        if (pwm_en !== 1'b1 || busy !== 1'b1 || count_val !== 16'd0 || period_tick !== 1'b0) begin
            errors++;
            $display("FAIL start_entry: pwm_en=%b busy=%b count=%0d tick=%b required 1/1/0/0",
                     pwm_en, busy, count_val, period_tick);
        end
        checks++;
        if (period !== 16'd10 || compare1 !== 16'd3 || compare2 !== 16'd7 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_cfg: period=%0d c1=%0d c2=%0d ready=%b required 10/3/7/1",
                     period, compare1, compare2, cfg_ready);
        end
        for (int k = 1; k <= 25; k++) begin
            step();
            checks++;
            if (count_val !== 16'(k % 10) || period_tick !== (k % 10 == 0) || pwm_en !== 1'b1) begin
                errors++;
                $display("FAIL start_count k=%0d: count=%0d tick=%b en=%b required %0d/%b/1",
                         k, count_val, period_tick, pwm_en, k % 10, (k % 10 == 0));
            end
        end
    endtask

    task automatic test_boundary_update();
        fresh_start(16'd10, 16'd3, 16'd0, 8'h00, 8'd0);
        repeat (4) step();
        cfg_valid = 1'b1;
        cfg_period = 16'd5;
        cfg_compare1 = 16'd2;
        step();
        cfg_valid = 1'b0;
        checks++;
        if (cfg_ready !== 1'b0 || period !== 16'd10 || count_val !== 16'd5) begin
            errors++;
            $display("FAIL upd_accept: ready=%b period=%0d count=%0d required 0/10/5",
                     cfg_ready, period, count_val);
        end
        for (int k = 6; k <= 9; k++) begin
            step();
            checks++;
            if (count_val !== 16'(k) || period !== 16'd10 || compare1 !== 16'd3) begin
                errors++;
                $display("FAIL upd_hold k=%0d: count=%0d period=%0d c1=%0d required %0d/10/3",
                         k, count_val, period, compare1, k);
            end
        end
        step();
        checks++;
        if (count_val !== 16'd0 || period_tick !== 1'b1 || period !== 16'd5 ||
            compare1 !== 16'd2 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL upd_wrap: count=%0d tick=%b period=%0d c1=%0d ready=%b required 0/1/5/2/1",
                     count_val, period_tick, period, compare1, cfg_ready);
        end
        for (int k = 11; k <= 20; k++) begin
            step();
            checks++;
            if (count_val !== 16'((k - 10) % 5) || period_tick !== ((k - 10) % 5 == 0)) begin
                errors++;
                $display("FAIL upd_new k=%0d: count=%0d tick=%b required %0d/%b",
                         k, count_val, period_tick, (k - 10) % 5, ((k - 10) % 5 == 0));
            end
        end
    endtask

    task automatic test_graceful_stop();
        fresh_start(16'd10, 16'd3, 16'd0, 8'h00, 8'd0);
        repeat (3) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        for (int k = 4; k <= 9; k++) begin
            checks++;
            if (count_val !== 16'(k) || pwm_en !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL stop_drain k=%0d: count=%0d en=%b busy=%b required %0d/1/1",
                         k, count_val, pwm_en, busy, k);
            end
            step();
        end
        checks++;
        if (count_val !== 16'd0 || pwm_en !== 1'b0 || busy !== 1'b0 || period_tick !== 1'b1) begin
            errors++;
            $display("FAIL stop_end: count=%0d en=%b busy=%b tick=%b required 0/0/0/1",
                     count_val, pwm_en, busy, period_tick);
        end
        repeat (3) step();
        checks++;
        if (count_val !== 16'd0 || pwm_en !== 1'b0 || period_tick !== 1'b0) begin
            errors++;
            $display("FAIL stop_idle: count=%0d en=%b tick=%b required 0/0/0",
                     count_val, pwm_en, period_tick);
        end

        fresh_start(16'd10, 16'd3, 16'd0, 8'h00, 8'd0);
        repeat (3) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        repeat (2) step();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 8; k <= 25; k++) begin
            step();
            checks++;
            if (count_val !== 16'(k % 10) || pwm_en !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL stop_cancel k=%0d: count=%0d en=%b busy=%b required %0d/1/1",
                         k, count_val, pwm_en, busy, k % 10);
            end
        end
    endtask

    task automatic test_simultaneous();
        fresh_start(16'd10, 16'd3, 16'd0, 8'h00, 8'd0);
        repeat (2) step();
        start = 1'b1;
        stop = 1'b1;
        step();
        start = 1'b0;
        stop = 1'b0;
        checks++;
        if (pwm_en !== 1'b1 || count_val !== 16'd3) begin
            errors++;
            $display("FAIL both_req: en=%b count=%0d required 1/3", pwm_en, count_val);
        end
        repeat (6) step();
        checks++;
        if (pwm_en !== 1'b1 || count_val !== 16'd9) begin
            errors++;
            $display("FAIL both_drain: en=%b count=%0d required 1/9", pwm_en, count_val);
        end
        step();
        checks++;
        if (pwm_en !== 1'b0 || count_val !== 16'd0 || period_tick !== 1'b1) begin
            errors++;
            $display("FAIL both_stop: en=%b count=%0d tick=%b required 0/0/1",
                     pwm_en, count_val, period_tick);
        end

        fresh_start(16'd10, 16'd3, 16'd0, 8'h00, 8'd0);
        repeat (9) step();
        cfg_valid = 1'b1;
        cfg_period = 16'd6;
        cfg_compare1 = 16'd1;
        step();
        cfg_valid = 1'b0;
        checks++;
        if (count_val !== 16'd0 || period_tick !== 1'b1 || period !== 16'd10 || cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL wrap_hs: count=%0d tick=%b period=%0d ready=%b required 0/1/10/0",
                     count_val, period_tick, period, cfg_ready);
        end
        repeat (9) step();
        checks++;
        if (count_val !== 16'd9 || period !== 16'd10) begin
            errors++;
            $display("FAIL wrap_hs_hold: count=%0d period=%0d required 9/10", count_val, period);
        end
        step();
        checks++;
        if (count_val !== 16'd0 || period !== 16'd6 || compare1 !== 16'd1 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL wrap_hs_apply: count=%0d period=%0d c1=%0d ready=%b required 0/6/1/1",
                     count_val, period, compare1, cfg_ready);
        end
        for (int k = 21; k <= 26; k++) begin
            step();
            checks++;
            if (count_val !== 16'((k - 20) % 6) || period_tick !== ((k - 20) % 6 == 0)) begin
                errors++;
                $display("FAIL wrap_hs_new k=%0d: count=%0d tick=%b required %0d/%b",
                         k, count_val, period_tick, (k - 20) % 6, ((k - 20) % 6 == 0));
            end
        end
    endtask

    task automatic test_prescale();
        fresh_start(16'd4, 16'd1, 16'd3, 8'h02, 8'd2);
        checks++;
        if (functions !== 8'h02 || compare2 !== 16'd3) begin
            errors++;
            $display("FAIL presc_cfg: func=%0d c2=%0d required 2/3", functions, compare2);
        end
        for (int k = 1; k <= 30; k++) begin
            step();
            checks++;
            if (count_val !== 16'((k / 3) % 4) || period_tick !== (k % 12 == 0)) begin
                errors++;
                $display("FAIL presc_count k=%0d: count=%0d tick=%b required %0d/%b",
                         k, count_val, period_tick, (k / 3) % 4, (k % 12 == 0));
            end
        end
        fresh_start(16'd1, 16'd0, 16'd0, 8'h00, 8'd2);
        for (int k = 1; k <= 12; k++) begin
            step();
            checks++;
            if (count_val !== 16'd0 || period_tick !== (k % 3 == 0)) begin
                errors++;
                $display("FAIL period1 k=%0d: count=%0d tick=%b required 0/%b",
                         k, count_val, period_tick, (k % 3 == 0));
            end
        end
    endtask

    task automatic test_reset_mid();
        fresh_start(16'd10, 16'd3, 16'd0, 8'h01, 8'd0);
        repeat (5) step();
        checks++;
        if (count_val !== 16'd5) begin
            errors++;
            $display("FAIL mid_pre: count=%0d required 5", count_val);
        end
        rst = 1'b1;
        step();
        checks++;
        if (count_val !== 16'd0 || pwm_en !== 1'b0 || busy !== 1'b0 || period_tick !== 1'b0 ||
            cfg_ready !== 1'b1 || period !== 16'd0 || compare1 !== 16'd0 || functions !== 8'd0) begin
            errors++;
            $display("FAIL mid_reset: count=%0d en=%b busy=%b tick=%b ready=%b per=%0d c1=%0d f=%0d required 0/0/0/0/1/0/0/0",
                     count_val, pwm_en, busy, period_tick, cfg_ready, period, compare1, functions);
        end
        rst = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        checks++;
        if (pwm_en !== 1'b0 || busy !== 1'b0 || count_val !== 16'd0) begin
            errors++;
            $display("FAIL mid_nocfg_start: en=%b busy=%b count=%0d required 0/0/0",
                     pwm_en, busy, count_val);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_boundary_update();
        test_graceful_stop();
        test_simultaneous();
        test_prescale();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
